// File: rtl/led_counter_ctrl.sv
// LED counter controller: button debounce, host command handshake, run/pause FSM
// and prescaled up/down stepping of the counter that drives the LEDs.
module led_counter_ctrl #(
  parameter int WIDTH           = 8,
  parameter int TICK_DIV        = 5000000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_raw,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             wrap
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_UP     = 2'b01,
    S_DOWN   = 2'b10,
    S_PAUSED = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    OP_STOP = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_LOAD = 2'b11
  } op_t;

  state_t           state_q, state_n;
  logic             dir_down_q, dir_down_n;
  logic [WIDTH-1:0] count_q, count_n;
  logic             wrap_q, wrap_n;
  logic [PW-1:0]    presc_q, presc_n;
  logic             ready_q;

  logic [1:0]       sync_q;
  logic [DW-1:0]    db_cnt_q;
  logic             db_level_q;
  logic             press_q;

  logic             db_done;
  logic             running;
  logic             tick;
  logic             accept;

  // Button path: two-flop synchronizer feeding a stability counter; only the
  // rising edge of the debounced level is turned into a press pulse.
  assign db_done = (sync_q[1] != db_level_q) && (db_cnt_q == DW'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q     <= '0;
      db_cnt_q   <= '0;
      db_level_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      press_q <= db_done && !db_level_q;
      if (sync_q[1] == db_level_q) begin
        db_cnt_q <= '0;
      end else if (db_done) begin
        db_level_q <= ~db_level_q;
        db_cnt_q   <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 1'b1;
      end
    end
  end

  assign running = (state_q == S_UP) || (state_q == S_DOWN);
  assign tick    = running && (presc_q == PW'(TICK_DIV - 1));
  assign accept  = cmd_valid && ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      dir_down_q <= 1'b0;
      count_q    <= '0;
      wrap_q     <= 1'b0;
      presc_q    <= '0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      dir_down_q <= dir_down_n;
      count_q    <= count_n;
      wrap_q     <= wrap_n;
      presc_q    <= presc_n;
      ready_q    <= 1'b1;
    end
  end

  // Priority: accepted command, then press, then tick. Lower-priority events
  // occurring in the same cycle are dropped, not deferred.
  always_comb begin
    state_n    = state_q;
    dir_down_n = dir_down_q;
    count_n    = count_q;
    wrap_n     = 1'b0;
    presc_n    = presc_q;

    if (running) begin
      presc_n = tick ? '0 : presc_q + 1'b1;
    end

    if (accept) begin
      unique case (op_t'(cmd_op))
        OP_STOP: begin
          state_n = S_IDLE;
          presc_n = presc_q;
        end
        OP_UP: begin
          state_n    = S_UP;
          dir_down_n = 1'b0;
          presc_n    = '0;
        end
        OP_DOWN: begin
          state_n    = S_DOWN;
          dir_down_n = 1'b1;
          presc_n    = '0;
        end
        OP_LOAD: begin
          count_n = cmd_data;
          presc_n = '0;
        end
        default: ;
      endcase
    end else if (press_q) begin
      unique case (state_q)
        S_IDLE: begin
          state_n    = S_UP;
          dir_down_n = 1'b0;
          presc_n    = '0;
        end
        S_UP, S_DOWN: begin
          state_n = S_PAUSED;
          presc_n = presc_q;
        end
        S_PAUSED: begin
          state_n = dir_down_q ? S_DOWN : S_UP;
          presc_n = '0;
        end
        default: ;
      endcase
    end else if (tick) begin
      if (state_q == S_UP) begin
        count_n = count_q + 1'b1;
        wrap_n  = (count_q == '1);
      end else begin
        count_n = count_q - 1'b1;
        wrap_n  = (count_q == '0);
      end
    end
  end

  assign cmd_ready = ready_q;
  assign count     = count_q;
  assign state     = state_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_led_counter_ctrl.sv
// Directed bench for led_counter_ctrl with a queue of expected values that is
// filled as each step is driven and drained as the DUT outputs are sampled.
module tb_led_counter_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_raw;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             wrap;

  led_counter_ctrl #(
    .WIDTH           (WIDTH),
    .TICK_DIV        (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .count     (count),
    .state     (state),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_err++;
      $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_err++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    step(1);
    cmd_valid = 1'b0;
  endtask

  task automatic expect_cw(input string tag, input logic [WIDTH-1:0] c, input logic w);
    push({tag, "_count"}, 32'(c));
    check(32'(count));
    push({tag, "_wrap"}, 32'(w));
    check(32'(wrap));
  endtask

  task automatic expect_state(input string tag, input logic [1:0] s);
    push(tag, 32'(s));
    check(32'(state));
  endtask

  task automatic hold_state(input string tag, input logic [1:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      step(1);
      expect_state(tag, s);
    end
  endtask

  // Bounded wait; an expired bound shows up as a state mismatch.
  task automatic wait_state(input string tag, input logic [1:0] s, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step(1);
      if (state === s) break;
    end
    expect_state(tag, s);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    btn_raw   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;

    step(2);
    expect_cw("rst", 8'h00, 1'b0);
    expect_state("rst_state", 2'b00);
    push("rst_ready", 32'd0);
    check(32'(cmd_ready));

    rst = 1'b0;
    step(1);
    push("ready_rise", 32'd1);
    check(32'(cmd_ready));

    // RUN_UP: one step every 4 edges, first one 4 edges after accept
    send(2'b01, '0);
    expect_state("up_state", 2'b01);
    expect_cw("up_accept", 8'h00, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      expect_cw("up_run", 8'(k / 4), 1'b0);
    end

    // LOAD 0xFE then RUN_UP: wrap pulses only alongside 0x00
    send(2'b11, 8'hFE);
    expect_cw("load_fe", 8'hFE, 1'b0);
    send(2'b01, '0);
    for (int k = 1; k <= 9; k++) begin
      step(1);
      if (k < 4)       expect_cw("wrap_up", 8'hFE, 1'b0);
      else if (k < 8)  expect_cw("wrap_up", 8'hFF, 1'b0);
      else if (k == 8) expect_cw("wrap_up", 8'h00, 1'b1);
      else             expect_cw("wrap_up", 8'h00, 1'b0);
    end

    // RUN_DOWN from 0x00 wraps to 0xFF
    send(2'b10, '0);
    expect_state("down_state", 2'b10);
    for (int k = 1; k <= 5; k++) begin
      step(1);
      if (k < 4)       expect_cw("wrap_down", 8'h00, 1'b0);
      else if (k == 4) expect_cw("wrap_down", 8'hFF, 1'b1);
      else             expect_cw("wrap_down", 8'hFF, 1'b0);
    end

    // 1- and 2-cycle glitches are shorter than the debounce window
    btn_raw = 1'b1;
    step(1);
    btn_raw = 1'b0;
    hold_state("glitch1", 2'b10, 4);
    btn_raw = 1'b1;
    step(2);
    btn_raw = 1'b0;
    hold_state("glitch2", 2'b10, 6);

    // Held press in RUN_DOWN pauses; the tick 4 edges after LOAD lands before the pause
    send(2'b11, 8'h40);
    btn_raw = 1'b1;
    wait_state("pause", 2'b11, 10);
    for (int k = 0; k < 6; k++) begin
      step(1);
      expect_cw("paused_frozen", 8'h3F, 1'b0);
    end
    btn_raw = 1'b0;
    hold_state("release_ignored", 2'b11, 8);
    expect_cw("paused_after_release", 8'h3F, 1'b0);

    // Second press resumes in the retained direction
    btn_raw = 1'b1;
    wait_state("resume_down", 2'b10, 10);
    btn_raw = 1'b0;
    hold_state("resume_release", 2'b10, 8);

    // LOAD on the same edge as a tick: loaded value is not stepped
    send(2'b01, '0);
    step(3);
    send(2'b11, 8'h55);
    expect_cw("load_on_tick", 8'h55, 1'b0);
    expect_state("load_on_tick_state", 2'b01);
    for (int k = 1; k <= 4; k++) begin
      step(1);
      expect_cw("after_load", (k < 4) ? 8'h55 : 8'h56, 1'b0);
    end

    // STOP held across the whole press window: every press collides with a command
    btn_raw   = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    for (int k = 0; k < 10; k++) begin
      step(1);
      expect_state("stop_vs_press", 2'b00);
      expect_cw("stop_hold", 8'h56, 1'b0);
    end
    cmd_valid = 1'b0;
    hold_state("press_discarded", 2'b00, 5);
    btn_raw = 1'b0;
    hold_state("stop_release", 2'b00, 8);

    // Reset mid-run with count 0x23 and a debounce in flight
    send(2'b11, 8'h23);
    send(2'b01, '0);
    btn_raw = 1'b1;
    step(3);
    expect_cw("pre_reset", 8'h23, 1'b0);
    expect_state("pre_reset_state", 2'b01);
    rst = 1'b1;
    step(1);
    expect_cw("mid_reset", 8'h00, 1'b0);
    expect_state("mid_reset_state", 2'b00);
    push("mid_reset_ready", 32'd0);
    check(32'(cmd_ready));
    rst     = 1'b0;
    btn_raw = 1'b0;
    step(1);
    push("post_reset_ready", 32'd1);
    check(32'(cmd_ready));
    for (int k = 0; k < 8; k++) begin
      step(1);
      expect_state("post_reset_idle", 2'b00);
      expect_cw("post_reset", 8'h00, 1'b0);
    end

    if (sb.size() != 0) begin
      n_err++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
